onehot_bcd_buffer: RTL and testbench

Registered stage directly downstream of the 8-input priority logic. It accepts the one-hot grant vector `h[7:0]` and the no-request flag, checks that they are well formed, and converts each accepted sample to a 4-bit BCD code (0–7) plus an idle bit. Codes go into a small FIFO that the BCD display/consumer side drains through a valid/ready handshake. Malformed patterns are dropped and recorded in a sticky error flag.

---
 rtl/bcd_enc_pkg.sv | 35 +++
 rtl/onehot_bcd_enc.sv | 23 ++
 rtl/onehot_bcd_buffer.sv | 107 ++++++++++
 tb/tb_onehot_bcd_buffer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_enc_pkg.sv
// Shared types and helpers for turning a one-hot grant vector into a BCD code.
package bcd_enc_pkg;

  localparam int BCD_W = 4;
  localparam int H_W   = 8;

  // One FIFO entry: the no-request marker plus the granted input index.
  typedef struct packed {
    logic             idle;
    logic [BCD_W-1:0] bcd;
  } bcd_entry_t;

  // Legal only when exactly one bit is set among the grant lines and idle.
  function automatic logic onehot_ok(input logic [H_W-1:0] h, input logic idle);
    logic [3:0] ones;
    ones = {3'b000, idle};
    for (int i = 0; i < H_W; i++) begin
      ones = ones + {3'b000, h[i]};
    end
    return ones == 4'd1;
  endfunction

  // Index of the set grant bit; on malformed input the lowest index wins so
  // the result is still well defined, but the caller is expected to drop it.
  function automatic bcd_entry_t onehot_to_bcd(input logic [H_W-1:0] h, input logic idle);
    bcd_entry_t e;
    e.idle = idle && (h == '0);
    e.bcd  = '0;
    for (int i = H_W - 1; i >= 0; i--) begin
      if (h[i]) e.bcd = BCD_W'(i);
    end
    return e;
  endfunction

endpackage

// File: rtl/onehot_bcd_enc.sv
// Combinational one-hot to BCD conversion with legality check.
module onehot_bcd_enc
  import bcd_enc_pkg::*;
(
  input  logic [7:0] h,
  input  logic       idle,
  output logic [3:0] bcd,
  output logic       bcd_idle,
  output logic       ok
);

  bcd_entry_t entry;

  // Convert the grant vector and flag whether it is well formed.
  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    entry    = onehot_to_bcd(h, idle);
    bcd      = entry.bcd;
    bcd_idle = entry.idle;
    ok       = onehot_ok(h, idle);
  end

endmodule

// File: rtl/onehot_bcd_buffer.sv
// Registered stage: validates one-hot grants, encodes them to BCD and queues
// the codes in a small FIFO drained by a valid/ready consumer. Malformed
// samples are swallowed and latched into a sticky error flag.
module onehot_bcd_buffer
  import bcd_enc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               h,
  input  logic                     idle,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_bcd,
  output logic                     out_idle,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_onehot,
  input  logic                     err_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  bcd_entry_t       mem [DEPTH];
  bcd_entry_t       head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0] enc_bcd;
  logic       enc_idle;
  logic       enc_ok;

  logic accept;
  logic push;
  logic pop;
  logic bad;

  onehot_bcd_enc u_enc (
    .h        (h),
    .idle     (idle),
    .bcd      (enc_bcd),
    .bcd_idle (enc_idle),
    .ok       (enc_ok)
  );

  // Handshake decode; in_ready depends only on registered occupancy, so a
  // pop in the same cycle never opens a slot for a full stage.
  always_comb begin
    in_ready  = (cnt_q != FULL_CNT);
    out_valid = (cnt_q != '0);
    accept    = in_valid && in_ready;
    push      = accept && enc_ok;
    bad       = accept && !enc_ok;
    pop       = out_valid && out_ready;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage, written only for well-formed accepted samples.
  // NOTE: storage has no reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{idle: enc_idle, bcd: enc_bcd};
    end
  end

  // Sticky malformed-input flag; a new error outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_onehot <= 1'b0;
    end else if (bad) begin
      err_onehot <= 1'b1;
    end else if (err_clr) begin
      err_onehot <= 1'b0;
    end
  end

  // Head presentation, forced to zero while the FIFO is empty.
  always_comb begin
    head     = mem[rd_ptr];
    out_bcd  = out_valid ? head.bcd  : '0;
    out_idle = out_valid ? head.idle : 1'b0;
    count    = cnt_q;
  end

endmodule

// File: tb/tb_onehot_bcd_buffer.sv
// Directed self-checking bench for onehot_bcd_buffer (DEPTH = 4).
module tb_onehot_bcd_buffer;

  logic       clk;
  logic       rst_n;
  logic [7:0] h;
  logic       idle;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_bcd;
  logic       out_idle;
  logic [2:0] count;
  logic       err_onehot;
  logic       err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  onehot_bcd_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .h          (h),
    .idle       (idle),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bcd    (out_bcd),
    .out_idle   (out_idle),
    .count      (count),
    .err_onehot (err_onehot),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one clock cycle of stimulus starting 1 time unit after a rising edge,
  // then return 1 unit after the next rising edge with inputs idle again.
  task automatic cycle(input logic [7:0] hv, input logic iv, input logic vld,
                       input logic rdy, input logic clr);
    h = hv; idle = iv; in_valid = vld; out_ready = rdy; err_clr = clr;
    @(posedge clk); #1;
    h = '0; idle = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; h = '0; idle = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    #12;
    check("rst_count",     count, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bcd",   out_bcd, 0);
    check("rst_out_idle",  out_idle, 0);
    check("rst_err",       err_onehot, 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single accept and pop
    cycle(8'b0000_0100, 1'b0, 1'b1, 1'b0, 1'b0);
    check("single_valid", out_valid, 1);
    check("single_bcd",   out_bcd, 2);
    check("single_idle",  out_idle, 0);
    check("single_count", count, 1);
    cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pop_count", count, 0);
    check("pop_valid", out_valid, 0);
    check("pop_bcd",   out_bcd, 0);

    // Idle sample
    cycle(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    check("idle_valid", out_valid, 1);
    check("idle_flag",  out_idle, 1);
    check("idle_bcd",   out_bcd, 0);
    cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_pop_count", count, 0);

    // Fill to full
    for (int k = 0; k < 4; k++) cycle(8'(1 << k), 1'b0, 1'b1, 1'b0, 1'b0);
    check("full_count", count, 4);
    check("full_ready", in_ready, 0);
    check("full_head",  out_bcd, 0);
    cycle(8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    check("refused_count", count, 4);
    check("refused_head",  out_bcd, 0);
    // Push offered with a pop while full: pop only, no bypass
    cycle(8'h20, 1'b0, 1'b1, 1'b1, 1'b0);
    check("full_pushpop_count", count, 3);
    check("full_pushpop_head",  out_bcd, 1);
    check("full_pushpop_ready", in_ready, 1);
    for (int k = 1; k < 4; k++) begin
      check($sformatf("drain_%0d", k), out_bcd, k);
      cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("drained_count", count, 0);
    check("drained_valid", out_valid, 0);

    // Pointer wrap with interleaved pops
    cycle(8'h10, 1'b0, 1'b1, 1'b0, 1'b0);   // 4
    cycle(8'h20, 1'b0, 1'b1, 1'b0, 1'b0);   // 5
    cycle(8'h40, 1'b0, 1'b1, 1'b1, 1'b0);   // push 6, pop 4
    check("wrap_pushpop_count", count, 2);
    check("wrap_pushpop_head",  out_bcd, 5);
    cycle(8'h80, 1'b0, 1'b1, 1'b0, 1'b0);   // 7
    check("wrap_count", count, 3);
    for (int k = 5; k < 8; k++) begin
      check($sformatf("wrap_drain_%0d", k), out_bcd, k);
      cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("wrap_empty", out_valid, 0);

    // Simultaneous push/pop at count 2, h bit 7
    cycle(8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(8'h08, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    check("sim_count", count, 2);
    check("sim_head3", out_bcd, 3);
    cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sim_head7", out_bcd, 7);
    cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sim_empty", count, 0);

    // Malformed inputs
    check("err_before", err_onehot, 0);
    cycle(8'b0001_0010, 1'b0, 1'b1, 1'b0, 1'b0);
    check("mal_two_err",   err_onehot, 1);
    check("mal_two_count", count, 0);
    check("mal_two_valid", out_valid, 0);
    cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_alone", err_onehot, 0);
    cycle(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("mal_zero_err",   err_onehot, 1);
    check("mal_zero_count", count, 0);
    cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_again", err_onehot, 0);
    cycle(8'h04, 1'b0, 1'b1, 1'b0, 1'b0);   // good entry, bcd 2
    cycle(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);   // h and idle together
    check("mal_both_err",   err_onehot, 1);
    check("mal_both_count", count, 1);
    check("mal_both_head",  out_bcd, 2);
    cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_third", err_onehot, 0);
    cycle(8'h03, 1'b0, 1'b1, 1'b0, 1'b1);
    check("set_wins", err_onehot, 1);
    check("set_wins_count", count, 1);

    // Reset mid-operation at count 3
    cycle(8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_rst_count", count, 3);
    #3 rst_n = 1'b0;
    #2;
    check("mid_rst_count",  count, 0);
    check("mid_rst_valid",  out_valid, 0);
    check("mid_rst_ready",  in_ready, 1);
    check("mid_rst_bcd",    out_bcd, 0);
    check("mid_rst_err",    err_onehot, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", out_valid, 0);
    check("post_rst_count", count, 0);
    cycle(8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    check("post_rst_head",  out_bcd, 6);
    check("post_rst_cnt1",  count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
